// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module   : branch_resolve_unit
// Brief    : Pairs in-order fetch-time prediction records with execute-stage
//            resolutions, updates the branch cache and issues mispredict
//            redirects. Optional statistics counters: BRANCH_RESOLVE_STAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module branch_resolve_unit #(
    parameter int QUEUE_DEPTH = 4,
    parameter int QUEUE_PTR_N = 2
) (
    input  logic        iCLOCK,
    input  logic        iRESET_SYNC,
    input  logic        iFLUSH,
    input  logic        iPREDICT_STB,
    input  logic [31:0] iPREDICT_INST_ADDR,
    input  logic        iPREDICT_HIT,
    input  logic        iPREDICT_BRANCH,
    input  logic [31:0] iPREDICT_ADDR,
    output logic        oPREDICT_FULL,
    input  logic        iRESOLVE_STB,
    input  logic        iRESOLVE_TAKEN,
    input  logic [31:0] iRESOLVE_ADDR,
    output logic        oJUMP_STB,
    output logic        oJUMP_HIT,
    output logic [31:0] oJUMP_ADDR,
    output logic [31:0] oJUMP_INST_ADDR,
    output logic        oMISS_STB,
    output logic [31:0] oMISS_ADDR,
    input  logic        iMISS_ACK,
    output logic        oRECOVER,
    output logic        oUNDERFLOW,
    output logic [31:0] oSTAT_RESOLVE_COUNT,
    output logic [31:0] oSTAT_MISS_COUNT
);

    localparam logic [QUEUE_PTR_N:0]   c_queue_depth = (QUEUE_PTR_N+1)'(QUEUE_DEPTH);
    localparam logic [QUEUE_PTR_N:0]   c_cnt_one     = (QUEUE_PTR_N+1)'(1);
    localparam logic [QUEUE_PTR_N-1:0] c_ptr_one     = QUEUE_PTR_N'(1);

    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_RECOVER = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [31:0] r_q_inst_addr [QUEUE_DEPTH];
    logic        r_q_hit       [QUEUE_DEPTH];
    logic        r_q_branch    [QUEUE_DEPTH];
    logic [31:0] r_q_addr      [QUEUE_DEPTH];

    logic [QUEUE_PTR_N-1:0] r_wptr;
    logic [QUEUE_PTR_N-1:0] r_rptr;
    logic [QUEUE_PTR_N:0]   r_count;

    logic        r_jump_stb;
    logic        r_jump_hit;
    logic [31:0] r_jump_addr;
    logic [31:0] r_jump_inst_addr;
    logic        r_miss_stb;
    logic [31:0] r_miss_addr;
    logic        r_underflow;

    logic        w_active;
    logic        w_empty;
    logic        w_full;
    logic        w_resolve;
    logic        w_underflow_evt;
    logic        w_push;
    logic [31:0] w_entry_inst_addr;
    logic [31:0] w_entry_addr;
    logic        w_pred_taken;
    logic        w_miss;

    // Reset and flush win over everything, and nothing is accepted in RECOVER.
    assign w_active          = !iRESET_SYNC && !iFLUSH && (r_state == ST_RUN);
    assign w_empty           = (r_count == '0);
    assign w_full            = (r_count == c_queue_depth);
    assign w_resolve         = w_active && iRESOLVE_STB && !w_empty;
    assign w_underflow_evt   = w_active && iRESOLVE_STB && w_empty;
    assign w_push            = w_active && iPREDICT_STB && (!w_full || w_resolve);
    assign w_entry_inst_addr = r_q_inst_addr[r_rptr];
    assign w_entry_addr      = r_q_addr[r_rptr];
    assign w_pred_taken      = r_q_hit[r_rptr] & r_q_branch[r_rptr];
    assign w_miss            = w_resolve &&
                               ((w_pred_taken != iRESOLVE_TAKEN) ||
                                (w_pred_taken && iRESOLVE_TAKEN && (w_entry_addr != iRESOLVE_ADDR)));

    always_ff @(posedge iCLOCK) begin
        if (w_push) begin
            r_q_inst_addr[r_wptr] <= iPREDICT_INST_ADDR;
            r_q_hit[r_wptr]       <= iPREDICT_HIT;
            r_q_branch[r_wptr]    <= iPREDICT_BRANCH;
            r_q_addr[r_wptr]      <= iPREDICT_ADDR;
        end
    end

    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            r_wptr           <= '0;
            r_rptr           <= '0;
            r_count          <= '0;
            r_jump_stb       <= 1'b0;
            r_jump_hit       <= 1'b0;
            r_jump_addr      <= '0;
            r_jump_inst_addr <= '0;
            r_miss_stb       <= 1'b0;
            r_miss_addr      <= '0;
            r_underflow      <= 1'b0;
        end else if (iFLUSH) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_jump_stb  <= 1'b0;
            r_miss_stb  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_jump_stb <= w_resolve;
            r_miss_stb <= w_miss;
            if (w_underflow_evt) begin
                r_underflow <= 1'b1;
            end
            if (w_resolve) begin
                r_jump_hit       <= ~iRESOLVE_TAKEN;
                r_jump_inst_addr <= w_entry_inst_addr;
                r_jump_addr      <= iRESOLVE_TAKEN ? iRESOLVE_ADDR : w_entry_addr;
            end
            if (w_miss) begin
                r_miss_addr <= iRESOLVE_TAKEN ? iRESOLVE_ADDR : (w_entry_inst_addr + 32'h4);
            end
            // A mispredict discards the whole queue, same-cycle push included.
            if (w_miss) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_count <= '0;
            end else begin
                if (w_push) begin
                    r_wptr <= r_wptr + c_ptr_one;
                end
                if (w_resolve) begin
                    r_rptr <= r_rptr + c_ptr_one;
                end
                if (w_push && !w_resolve) begin
                    r_count <= r_count + c_cnt_one;
                end else if (!w_push && w_resolve) begin
                    r_count <= r_count - c_cnt_one;
                end
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (iFLUSH) begin
            w_state_next = ST_RUN;
        end else begin
            case (r_state)
                ST_RUN:     if (w_miss)    w_state_next = ST_RECOVER;
                ST_RECOVER: if (iMISS_ACK) w_state_next = ST_RUN;
                default:                   w_state_next = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

`ifdef BRANCH_RESOLVE_STAT_EN
    logic [31:0] r_stat_resolve;
    logic [31:0] r_stat_miss;

    // Counters survive flush; only reset clears them.
    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            r_stat_resolve <= '0;
            r_stat_miss    <= '0;
        end else begin
            if (w_resolve && (r_stat_resolve != 32'hFFFF_FFFF)) begin
                r_stat_resolve <= r_stat_resolve + 32'd1;
            end
            if (w_miss && (r_stat_miss != 32'hFFFF_FFFF)) begin
                r_stat_miss <= r_stat_miss + 32'd1;
            end
        end
    end

    assign oSTAT_RESOLVE_COUNT = r_stat_resolve;
    assign oSTAT_MISS_COUNT    = r_stat_miss;
`else
    assign oSTAT_RESOLVE_COUNT = 32'h0;
    assign oSTAT_MISS_COUNT    = 32'h0;
`endif

    assign oPREDICT_FULL   = w_full;
    assign oJUMP_STB       = r_jump_stb;
    assign oJUMP_HIT       = r_jump_hit;
    assign oJUMP_ADDR      = r_jump_addr;
    assign oJUMP_INST_ADDR = r_jump_inst_addr;
    assign oMISS_STB       = r_miss_stb;
    assign oMISS_ADDR      = r_miss_addr;
    assign oRECOVER        = (r_state == ST_RECOVER);
    assign oUNDERFLOW      = r_underflow;

endmodule
`default_nettype wire

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Write-side partner of the branch cache. It holds in-order fetch-time prediction records and pairs each with its in-order execute-stage resolution.
- Per resolution it drives the branch cache update strobe (oJUMP_*) and, on a mispredict, a one-shot fetch redirect.
- It then holds recovery until fetch acknowledges the redirect.
- Sits between fetch (prediction records), execute (branch outcomes) and the branch cache update port.

Parameters:
QUEUE_DEPTH, 4, prediction queue entries; power of 2, minimum 2.
QUEUE_PTR_N, 2, log2(QUEUE_DEPTH).

Ports:
iCLOCK  in  1  clock
iRESET_SYNC  in  1  reset; synchronous, active-high
iFLUSH  in  1  pipeline flush; empties queue, returns FSM to RUN
iPREDICT_STB  in  1  fetch pushes one prediction record
iPREDICT_INST_ADDR  in  32  branch instruction address
iPREDICT_HIT  in  1  branch cache hit at fetch
iPREDICT_BRANCH  in  1  predicted taken (meaningful only when HIT=1)
iPREDICT_ADDR  in  32  predicted target
oPREDICT_FULL  out  1  queue full (combinational from count)
iRESOLVE_STB  in  1  execute resolves oldest outstanding branch
iRESOLVE_TAKEN  in  1  actual direction
iRESOLVE_ADDR  in  32  actual target (valid when TAKEN=1)
oJUMP_STB  out  1  branch cache update strobe
oJUMP_HIT  out  1  1 = resolved not-taken, 0 = taken (branch cache counter convention)
oJUMP_ADDR  out  32  target written to branch cache
oJUMP_INST_ADDR  out  32  branch instruction address
oMISS_STB  out  1  one-cycle mispredict redirect pulse
oMISS_ADDR  out  32  redirect fetch address
iMISS_ACK  in  1  fetch has taken the redirect
oRECOVER  out  1  FSM in RECOVER
oUNDERFLOW  out  1  sticky: resolve arrived with queue empty
oSTAT_RESOLVE_COUNT  out  32  see Optional Feature
oSTAT_MISS_COUNT  out  32  see Optional Feature

Behaviour:
- Reset:
  - All registered outputs 0, queue empty (wptr=rptr=count=0), FSM=RUN.
  - iRESET_SYNC has priority over iFLUSH over everything else.
- Queue:
  - Circular buffer of {inst_addr, hit, branch, addr}; pointers wrap modulo QUEUE_DEPTH.
  - Push when iPREDICT_STB && FSM==RUN && (count<QUEUE_DEPTH || pop this cycle).
  - Push when full with no pop: record dropped, no state change.
  - Push while RECOVER: ignored.
- Pop/resolve:
  - iRESOLVE_STB with count>0 pops the entry at rptr.
  - No same-cycle bypass: a push and a resolve on an empty queue make the resolve an underflow, so oUNDERFLOW=1 and no pop. The push still occurs.
  - oUNDERFLOW is cleared only by reset or flush.
- Resolve outputs, registered, latency 1 cycle from iRESOLVE_STB:
  - oJUMP_STB=1 for one cycle.
  - oJUMP_HIT = ~iRESOLVE_TAKEN.
  - oJUMP_INST_ADDR = entry.inst_addr.
  - oJUMP_ADDR = iRESOLVE_ADDR if taken, else entry.addr.
- Mispredict conditions:
  - pred_taken = entry.hit & entry.branch.
  - miss = (pred_taken != TAKEN) | (pred_taken & TAKEN & entry.addr != iRESOLVE_ADDR).
- On miss, registered, same cycle as oJUMP_STB:
  - oMISS_STB=1 for one cycle.
  - oMISS_ADDR = TAKEN ? iRESOLVE_ADDR : entry.inst_addr + 32'h4.
  - Queue cleared, including any same-cycle push (wrong path). FSM -> RECOVER.
- FSM:
  - RUN -> RECOVER on miss.
  - RECOVER -> RUN on iMISS_ACK.
  - Resolves in RECOVER are ignored: no update, no underflow.
  - iMISS_ACK in RUN is ignored.
- iFLUSH: queue cleared, FSM=RUN, pending oJUMP_STB/oMISS_STB next cycle suppressed to 0.
- Resolve outputs hold their last value when strobes are 0.

Optional Feature:
- Macro BRANCH_RESOLVE_STAT_EN.
- Defined:
  - oSTAT_RESOLVE_COUNT increments on each accepted resolve.
  - oSTAT_MISS_COUNT increments on each miss.
  - Both saturate at 32'hFFFFFFFF, are cleared by iRESET_SYNC only (not iFLUSH), and are registered.
- Undefined: both ports tied to 32'h0, no counter registers.

Test Plan:
- Reset, then push {0x100, hit=1, br=1, 0x200}, resolve taken addr 0x200 -> next cycle oJUMP_STB=1, HIT=0, JUMP_ADDR=0x200, JUMP_INST_ADDR=0x100, oMISS_STB=0.
- Push {0x104, hit=1, br=1, 0x300}, resolve not-taken -> oJUMP_HIT=1, oMISS_STB=1, oMISS_ADDR=0x108, oRECOVER=1. A push is ignored until iMISS_ACK, after which oRECOVER=0.
- Push 4 records -> oPREDICT_FULL=1. A 5th push without resolve is dropped. Push plus resolve in the same cycle is accepted, count stays 4, and the resolve order matches push order.
- Push {0x40, hit=0} and resolve taken 0x80 -> miss, oMISS_ADDR=0x80, oJUMP_ADDR=0x80. A target mismatch (pred 0x90, actual 0x80) also misses.
- Resolve with empty queue -> oUNDERFLOW=1, oJUMP_STB=0. iFLUSH clears oUNDERFLOW. iFLUSH during RECOVER returns to RUN.
- With BRANCH_RESOLVE_STAT_EN: 3 resolves, 1 miss -> counts 3 and 1. iFLUSH leaves them unchanged, iRESET_SYNC clears them.
